// File: rtl/router_pkt_gen_if.sv
// router_pkt_gen_if: byte stream from the packet generator
// to the router input register stage, with busy backpressure.
interface router_pkt_gen_if;
  logic       pkt_valid;
  logic [7:0] data_out;
  logic       busy;

  modport master (
    output pkt_valid,
    output data_out,
    input  busy
  );

  modport slave (
    input  pkt_valid,
    input  data_out,
    output busy
  );
endinterface

// File: rtl/router_pkt_gen.sv
// router_pkt_gen: emits header, buffered payload and parity
// bytes to the 1x3 router, honouring busy and an idle gap.
module router_pkt_gen #(
  parameter int MIN_GAP = 2,
  parameter int MAX_LEN = 63
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [5:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       start,
  input  logic [1:0] dest_addr,
  input  logic [5:0] pay_len,
  input  logic       inject_err,
  router_pkt_gen_if.master rt,
  output logic       gen_active,
  output logic       done,
  output logic       cfg_err
);

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    PAYLOAD,
    PARITY,
    GAP
  } state_t;

  state_t     state, state_n;
  logic [7:0] data_q, data_n;
  logic       valid_q, valid_n;
  logic       done_n, cfg_n;
  logic [7:0] par_q, par_n;
  logic [5:0] idx_q, idx_n;
  logic [5:0] len_q, len_n;
  logic       inj_q, inj_n;
  logic [3:0] gap_q, gap_n;

  logic [7:0] mem [64];
  logic [5:0] nidx;
  logic       at_end;
  logic       accept;
  logic [7:0] par_acc;

  assign nidx    = idx_q + 6'd1;
  assign accept  = !rt.busy;
  assign par_acc = par_q ^ data_q;
  // the length field caps the index, so no wrap past MAX_LEN-1
  assign at_end  = (idx_q == len_q - 6'd1) ||
                   (idx_q == 6'(MAX_LEN - 1));

  // payload buffer is only writable between packets
  always_ff @(posedge clock) begin
    if (wr_en && state == IDLE)
      mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      done    <= 1'b0;
      cfg_err <= 1'b0;
      par_q   <= 8'h00;
      idx_q   <= 6'd0;
      len_q   <= 6'd0;
      inj_q   <= 1'b0;
      gap_q   <= 4'd0;
    end else begin
      state   <= state_n;
      data_q  <= data_n;
      valid_q <= valid_n;
      done    <= done_n;
      cfg_err <= cfg_n;
      par_q   <= par_n;
      idx_q   <= idx_n;
      len_q   <= len_n;
      inj_q   <= inj_n;
      gap_q   <= gap_n;
    end
  end

  always_comb begin
    state_n = state;
    data_n  = data_q;
    valid_n = valid_q;
    done_n  = 1'b0;
    cfg_n   = 1'b0;
    par_n   = par_q;
    idx_n   = idx_q;
    len_n   = len_q;
    inj_n   = inj_q;
    gap_n   = gap_q;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (pay_len == 6'd0 || dest_addr == 2'b11) begin
            cfg_n = 1'b1;
          end else begin
            len_n   = pay_len;
            inj_n   = inject_err;
            data_n  = {pay_len, dest_addr};
            par_n   = {pay_len, dest_addr};
            valid_n = 1'b1;
            state_n = HEADER;
          end
        end
      end
      HEADER: begin
        if (accept) begin
          idx_n   = 6'd0;
          data_n  = mem[0];
          state_n = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (accept) begin
          par_n = par_acc;
          if (at_end) begin
            valid_n = 1'b0;
            data_n  = par_acc ^ {7'b0, inj_q};
            state_n = PARITY;
          end else begin
            idx_n  = nidx;
            data_n = mem[nidx];
          end
        end
      end
      PARITY: begin
        if (accept) begin
          done_n  = 1'b1;
          data_n  = 8'h00;
          gap_n   = 4'(MIN_GAP);
          state_n = GAP;
        end
      end
      GAP: begin
        gap_n = gap_q - 4'd1;
        if (gap_q <= 4'd1)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign rt.pkt_valid = valid_q;
  assign rt.data_out  = data_q;
  assign gen_active   = (state != IDLE);

endmodule

// File: doc/router_pkt_gen.md
Name: router_pkt_gen

Overview:
- Source-side packet generator for the 1x3 router; builds and drives the byte stream that the router's input register stage consumes.
- Emits a header byte {length[5:0], addr[1:0]}, then the payload bytes, then one parity byte. The parity is the XOR of the header and all payload bytes.
- Payload is preloaded into an internal 64x8 buffer through a write port. The block honours the router's busy backpressure and enforces a minimum idle gap between packets.
- Used by test harnesses and by the upstream packetiser.

Parameters:
- MIN_GAP, 2, minimum idle cycles with pkt_valid=0 between the end of a parity byte and the next header (legal range 1..15)
- MAX_LEN, 63, maximum payload length in bytes (fixed by the 6-bit length field)

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- wr_en  in  1  payload buffer write strobe
- wr_addr  in  6  payload buffer write index
- wr_data  in  8  payload byte
- start  in  1  request to transmit one packet
- dest_addr  in  2  destination port (0..2)
- pay_len  in  6  payload length (1..63)
- inject_err  in  1  sampled with start; when set, the transmitted parity is inverted in bit 0
- busy  in  1  router backpressure; when high, the current byte is not consumed
- pkt_valid  out  1  high during header and payload bytes; low during the parity byte
- data_out  out  8  byte presented to the router
- gen_active  out  1  high from the HEADER state through the end of the idle gap
- done  out  1  one-cycle pulse after the parity byte is accepted
- cfg_err  out  1  one-cycle pulse when start is rejected

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE; pkt_valid=0, data_out=8'h00, gen_active=0, done=0, cfg_err=0.
  - Gap counter and running parity cleared.
  - Buffer contents are not cleared.
- Byte acceptance rule:
  - A byte is consumed on a rising edge where the state is HEADER, PAYLOAD or PARITY and busy=0.
  - While busy=1, data_out and pkt_valid hold their values exactly and no counter advances.
- Buffer writes:
  - wr_en is honoured only in IDLE; it is ignored in every other state.
  - Writes take effect at the clock edge.
- FSM states: IDLE, HEADER, PAYLOAD, PARITY, GAP.
  - IDLE, start=1:
    - If pay_len=0 or dest_addr=2'b11: cfg_err pulses the next cycle and the FSM stays in IDLE.
    - Otherwise: latch len, dest and inject_err, then go to HEADER. data_out={pay_len,dest_addr} and pkt_valid=1 on the next cycle (latency 1 cycle).
    - Running parity is loaded with the header byte.
  - HEADER:
    - On acceptance, go to PAYLOAD with index=0 and data_out=buf[0].
  - PAYLOAD:
    - On each acceptance: parity ^= data_out, index increments, data_out = buf[index+1].
    - When the byte at index=len-1 is accepted: go to PARITY. pkt_valid=0, data_out = final parity ^ {7'b0, inject_err_latched}.
  - PARITY:
    - On acceptance: done=1 for one cycle, data_out=8'h00, load the gap counter with MIN_GAP, go to GAP.
  - GAP:
    - Counter decrements each cycle; go to IDLE when it reaches 0.
    - start is ignored in GAP (not queued).
- gen_active = (state != IDLE).
- Unbusied timing: a packet occupies len+2 cycles on the wire. The next header appears no earlier than MIN_GAP+1 cycles after the last parity cycle.
- Parity arithmetic: 8-bit XOR; no carry; header byte included.
- Edge cases:
  - start together with busy=1 in IDLE: accepted; HEADER is then held until busy drops.
  - busy asserted on the parity byte: parity holds with pkt_valid=0, and done is delayed accordingly.
  - pay_len=63: index reaches 62, with no wrap.
  - Reset mid-packet: outputs drop asynchronously. A partial packet is truncated, and the router-side recovery is the router's concern.

Test Plan:
1. Write buf[0..2]=8'h11,22,33; start dest=1, len=3, busy=0 -> data_out sequence 8'h0D,11,22,33 with pkt_valid=1, then 8'h0D^11^22^33=8'h0D (parity) with pkt_valid=0; done pulses the following cycle; total length 5 cycles.
2. Same packet with busy=1 for 3 cycles during byte 8'h22 -> 8'h22 is held for 4 cycles, pkt_valid stays 1, and the parity is unchanged.
3. start with len=0, then with dest=2'b11 -> cfg_err pulses each time; pkt_valid never rises; state stays IDLE.
4. len=63 of incrementing data (buf[i]=i), dest=2 -> header 8'hFE, 63 payload bytes 0..62, then parity = 8'hFE ^ XOR(0..62).
5. inject_err=1 with the case 1 packet -> parity byte 8'h0C, all other bytes identical to case 1.
6. Back-to-back start held high, MIN_GAP=2 -> at least 2 idle cycles between parity and the next header; reset asserted mid-PAYLOAD -> pkt_valid=0 and data_out=8'h00 immediately, followed by a clean packet after reset is released.
